// File: rtl/sopc_rst_ctrl.sv
// Sequenced multi-domain reset controller: sync release, hold, staggered release, run timer.
// Optional run-limit timer (DONE state, run_done) is compiled in with `define RUN_LIMIT_EN.
module sopc_rst_ctrl #(
  parameter int NUM_DOMAINS = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGGER     = 4,
  parameter int RUN_LIMIT   = 250
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic                   run_done,
  output logic [15:0]            cycle_cnt
);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
      STAGGER < 0 || STAGGER > 255 ||
      RUN_LIMIT < 1 || RUN_LIMIT > 65535) begin : g_bad_param
    $error("sopc_rst_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  STG_LAST  = 8'(STAGGER - 1);
  localparam logic [NUM_DOMAINS-1:0] ALL1 = '1;

  state_t                 state;
  state_t                 state_n;
  logic [1:0]             sync;
  logic                   rel;
  logic [15:0]            hold_cnt;
  logic [15:0]            hold_n;
  logic [7:0]             stg_cnt;
  logic [7:0]             stg_n;
  logic [NUM_DOMAINS-1:0] rst_out_n;
  logic                   ready_n;
  logic [15:0]            cnt_n;
  logic [15:0]            cnt_inc;

  assign rel = sync[1];
  assign cnt_inc = (cycle_cnt == 16'hFFFF) ? cycle_cnt
                                           : cycle_cnt + 16'd1;

`ifdef RUN_LIMIT_EN
  localparam logic [15:0] LIMIT = 16'(RUN_LIMIT);
  logic done_q;
  logic done_n;
  assign run_done = done_q;
`else
  assign run_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HOLD;
      hold_cnt  <= 16'd0;
      stg_cnt   <= 8'd0;
      rst_out   <= ALL1;
      ready     <= 1'b0;
      cycle_cnt <= 16'd0;
`ifdef RUN_LIMIT_EN
      done_q    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      stg_cnt   <= stg_n;
      rst_out   <= rst_out_n;
      ready     <= ready_n;
      cycle_cnt <= cnt_n;
`ifdef RUN_LIMIT_EN
      done_q    <= done_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    stg_n     = stg_cnt;
    rst_out_n = rst_out;
    ready_n   = ready;
    cnt_n     = cycle_cnt;
`ifdef RUN_LIMIT_EN
    done_n    = done_q;
`endif
    unique case (state)
      HOLD: begin
        if (rel) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_n = 16'd0;
            stg_n  = 8'd0;
            // Zeros shift in from bit 0, so domain 0 leaves reset first.
            if (STAGGER == 0) begin
              rst_out_n = '0;
            end else begin
              rst_out_n = rst_out << 1;
            end
            if (rst_out_n == '0) begin
              state_n = RUN;
              ready_n = 1'b1;
              cnt_n   = 16'd0;
            end else begin
              state_n = RELEASE;
            end
          end else begin
            hold_n = hold_cnt + 16'd1;
          end
        end
      end
      RELEASE: begin
        if (stg_cnt == STG_LAST) begin
          stg_n     = 8'd0;
          rst_out_n = rst_out << 1;
          if (rst_out_n == '0) begin
            state_n = RUN;
            ready_n = 1'b1;
            cnt_n   = 16'd0;
          end
        end else begin
          stg_n = stg_cnt + 8'd1;
        end
      end
      RUN: begin
        cnt_n = cnt_inc;
`ifdef RUN_LIMIT_EN
        if (cnt_n == LIMIT) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
`endif
      end
      DONE: begin
        cnt_n = cnt_inc;
      end
      default: begin
        state_n = HOLD;
      end
    endcase
    // Soft request overrides every transition above, including RUN->DONE.
    if (soft_rst_req) begin
      state_n   = HOLD;
      hold_n    = 16'd0;
      stg_n     = 8'd0;
      rst_out_n = ALL1;
      ready_n   = 1'b0;
      cnt_n     = 16'd0;
`ifdef RUN_LIMIT_EN
      done_n    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_sopc_rst_ctrl.sv
// Directed bench for sopc_rst_ctrl: a 2-domain staggered instance
// and a 4-domain zero-stagger instance used for saturation.
module tb_sopc_rst_ctrl;

  logic        clk;
  logic        rst1;
  logic        soft1;
  logic [1:0]  ro1;
  logic        rdy1;
  logic        rd1;
  logic [15:0] cnt1;
  logic        rst2;
  logic        soft2;
  logic [3:0]  ro2;
  logic        rdy2;
  logic        rd2;
  logic [15:0] cnt2;

  int n_chk;
  int n_fail;
  logic rl_en;

  sopc_rst_ctrl #(
    .NUM_DOMAINS(2),
    .HOLD_CYCLES(10),
    .STAGGER(4),
    .RUN_LIMIT(20)
  ) dut1 (
    .clk(clk),
    .rst(rst1),
    .soft_rst_req(soft1),
    .rst_out(ro1),
    .ready(rdy1),
    .run_done(rd1),
    .cycle_cnt(cnt1)
  );

  sopc_rst_ctrl #(
    .NUM_DOMAINS(4),
    .HOLD_CYCLES(3),
    .STAGGER(0),
    .RUN_LIMIT(65535)
  ) dut2 (
    .clk(clk),
    .rst(rst2),
    .soft_rst_req(soft2),
    .rst_out(ro2),
    .ready(rdy2),
    .run_done(rd2),
    .cycle_cnt(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    n_chk++;
    if (ro1 !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ro1: got %b expected 11", ro1);
    end
    n_chk++;
    if (rdy1 !== 1'b0 || rd1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags1: got rdy=%b rd=%b expected 0 0", rdy1, rd1);
    end
    n_chk++;
    if (cnt1 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt1: got %0d expected 0", cnt1);
    end
    n_chk++;
    if (ro2 !== 4'b1111 || rdy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut2: got ro=%b rdy=%b expected 1111 0", ro2, rdy2);
    end
  endtask

  task automatic test_release;
    rst1 = 1'b1;
    tick(11);
    n_chk++;
    if (ro1 !== 2'b11) begin
      n_fail++;
      $display("FAIL rel_edge11: got %b expected 11", ro1);
    end
    tick(1);
    n_chk++;
    if (ro1 !== 2'b10 || rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_edge12: got ro=%b rdy=%b expected 10 0", ro1, rdy1);
    end
    tick(3);
    n_chk++;
    if (ro1 !== 2'b10) begin
      n_fail++;
      $display("FAIL rel_edge15: got %b expected 10", ro1);
    end
    tick(1);
    n_chk++;
    if (ro1 !== 2'b00 || rdy1 !== 1'b1 || cnt1 !== 16'd0) begin
      n_fail++;
      $display("FAIL rel_edge16: got ro=%b rdy=%b cnt=%0d expected 00 1 0",
               ro1, rdy1, cnt1);
    end
    tick(1);
    n_chk++;
    if (cnt1 !== 16'd1) begin
      n_fail++;
      $display("FAIL run_cnt1: got %0d expected 1", cnt1);
    end
  endtask

  task automatic test_run_limit;
    tick(18);
    n_chk++;
    if (cnt1 !== 16'd19 || rd1 !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_before: got cnt=%0d rd=%b expected 19 0", cnt1, rd1);
    end
    tick(1);
    n_chk++;
    if (cnt1 !== 16'd20 || rd1 !== rl_en) begin
      n_fail++;
      $display("FAIL limit_hit: got cnt=%0d rd=%b expected 20 %b",
               cnt1, rd1, rl_en);
    end
    tick(1);
    n_chk++;
    if (cnt1 !== 16'd21 || rd1 !== rl_en || ro1 !== 2'b00) begin
      n_fail++;
      $display("FAIL limit_after: got cnt=%0d rd=%b ro=%b expected 21 %b 00",
               cnt1, rd1, ro1, rl_en);
    end
  endtask

  task automatic test_async_reset;
    #2;
    rst1 = 1'b0;
    #1;
    n_chk++;
    if (ro1 !== 2'b11 || cnt1 !== 16'd0 || rd1 !== 1'b0 || rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got ro=%b cnt=%0d rd=%b rdy=%b expected 11 0 0 0",
               ro1, cnt1, rd1, rdy1);
    end
    tick(2);
  endtask

  task automatic test_soft_hold;
    rst1 = 1'b1;
    tick(6);
    soft1 = 1'b1;
    tick(1);
    soft1 = 1'b0;
    tick(9);
    n_chk++;
    if (ro1 !== 2'b11) begin
      n_fail++;
      $display("FAIL soft_hold_wait: got %b expected 11", ro1);
    end
    tick(1);
    n_chk++;
    if (ro1 !== 2'b10) begin
      n_fail++;
      $display("FAIL soft_hold_rel: got %b expected 10", ro1);
    end
    rst1 = 1'b0;
    tick(2);
  endtask

  task automatic test_soft_release;
    rst1 = 1'b1;
    tick(13);
    soft1 = 1'b1;
    tick(1);
    soft1 = 1'b0;
    n_chk++;
    if (ro1 !== 2'b11 || rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_rel_reassert: got ro=%b rdy=%b expected 11 0", ro1, rdy1);
    end
    tick(9);
    n_chk++;
    if (ro1 !== 2'b11) begin
      n_fail++;
      $display("FAIL soft_rel_hold: got %b expected 11", ro1);
    end
    tick(1);
    n_chk++;
    if (ro1 !== 2'b10) begin
      n_fail++;
      $display("FAIL soft_rel_bit0: got %b expected 10", ro1);
    end
    tick(4);
    n_chk++;
    if (ro1 !== 2'b00 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL soft_rel_done: got ro=%b rdy=%b expected 00 1", ro1, rdy1);
    end
  endtask

  task automatic test_soft_run;
    tick(5);
    n_chk++;
    if (cnt1 !== 16'd5) begin
      n_fail++;
      $display("FAIL soft_run_pre: got %0d expected 5", cnt1);
    end
    soft1 = 1'b1;
    tick(1);
    soft1 = 1'b0;
    n_chk++;
    if (ro1 !== 2'b11 || rdy1 !== 1'b0 || cnt1 !== 16'd0 || rd1 !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_run: got ro=%b rdy=%b cnt=%0d rd=%b expected 11 0 0 0",
               ro1, rdy1, cnt1, rd1);
    end
  endtask

  task automatic test_stagger0;
    rst2 = 1'b1;
    tick(4);
    n_chk++;
    if (ro2 !== 4'b1111 || rdy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL stg0_before: got ro=%b rdy=%b expected 1111 0", ro2, rdy2);
    end
    tick(1);
    n_chk++;
    if (ro2 !== 4'b0000 || rdy2 !== 1'b1 || cnt2 !== 16'd0) begin
      n_fail++;
      $display("FAIL stg0_release: got ro=%b rdy=%b cnt=%0d expected 0000 1 0",
               ro2, rdy2, cnt2);
    end
  endtask

  task automatic test_saturate;
    tick(65534);
    n_chk++;
    if (cnt2 !== 16'hFFFE || rd2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_pre: got cnt=%h rd=%b expected fffe 0", cnt2, rd2);
    end
    tick(1);
    n_chk++;
    if (cnt2 !== 16'hFFFF || rd2 !== rl_en) begin
      n_fail++;
      $display("FAIL sat_hit: got cnt=%h rd=%b expected ffff %b", cnt2, rd2, rl_en);
    end
    tick(5);
    n_chk++;
    if (cnt2 !== 16'hFFFF || rd2 !== rl_en || ro2 !== 4'b0000) begin
      n_fail++;
      $display("FAIL sat_hold: got cnt=%h rd=%b ro=%b expected ffff %b 0000",
               cnt2, rd2, ro2, rl_en);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
`ifdef RUN_LIMIT_EN
    rl_en = 1'b1;
`else
    rl_en = 1'b0;
`endif
    rst1  = 1'b0;
    rst2  = 1'b0;
    soft1 = 1'b0;
    soft2 = 1'b0;
    tick(3);
    test_reset;
    test_release;
    test_run_limit;
    test_async_reset;
    test_soft_hold;
    test_soft_release;
    test_soft_run;
    test_stagger0;
    test_saturate;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
